pipe_reg_bank: RTL and testbench

- Parametrised bank of pipeline registers for the Y86-64 pipelined processor.
- Replaces the fixed, control-less F/D/E/M/W registers with N uniform stages. Each stage has stall and bubble control, a valid bit, icode and stat fields, and a generic payload.
- Freezes the whole pipeline when an exceptional status (HLT/ADR/INS) reaches the last stage.
- Keeps cycle and retired-instruction performance counters.
- Sits between the per-stage combinational logic (fetch, decode/regfile, execute, memory) and the hazard-control unit, which drives stall/bubble.

---
 rtl/y86_pkg.sv | 21 ++
 rtl/pipe_reg_bank_stage.sv | 45 ++++
 rtl/pipe_reg_bank.sv | 106 ++++++++++
 tb/tb_pipe_reg_bank.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 pipeline constants: status codes, icode values
// and the exceptional-status helper.
package y86_pkg;

  localparam int STAT_W  = 3;
  localparam int ICODE_W = 4;

  localparam logic [STAT_W-1:0] STAT_AOK = 3'd1;
  localparam logic [STAT_W-1:0] STAT_HLT = 3'd2;
  localparam logic [STAT_W-1:0] STAT_ADR = 3'd3;
  localparam logic [STAT_W-1:0] STAT_INS = 3'd4;

  localparam logic [ICODE_W-1:0] ICODE_HALT = 4'h0;
  localparam logic [ICODE_W-1:0] ICODE_NOP  = 4'h1;

  // Any status other than AOK stops the machine once it reaches W.
  function automatic logic is_exc(input logic [STAT_W-1:0] st);
    return st != STAT_AOK;
  endfunction

endpackage

// File: rtl/pipe_reg_bank_stage.sv
// One pipeline register: freeze > stall > bubble > load,
// with a NOP/AOK/zero-payload reset and bubble value.
module pipe_stage
  import y86_pkg::*;
#(
  parameter int WIDTH = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               stall,
  input  logic               bubble,
  input  logic               in_valid,
  input  logic [ICODE_W-1:0] in_icode,
  input  logic [STAT_W-1:0]  in_stat,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  output logic [ICODE_W-1:0] out_icode,
  output logic [STAT_W-1:0]  out_stat,
  output logic [WIDTH-1:0]   out_data
);

  // Stage register; freeze or stall hold every field.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_icode <= ICODE_NOP;
      out_stat  <= STAT_AOK;
      out_data  <= '0;
    end else if (!freeze && !stall) begin
      if (bubble) begin
        out_valid <= 1'b0;
        out_icode <= ICODE_NOP;
        out_stat  <= STAT_AOK;
        out_data  <= '0;
      end else begin
        out_valid <= in_valid;
        out_icode <= in_icode;
        out_stat  <= in_stat;
        out_data  <= in_data;
      end
    end
  end

endmodule

// File: rtl/pipe_reg_bank.sv
// Bank of NSTAGES uniform pipeline registers with halt freeze,
// control-error flag and cycle/retire performance counters.
module pipe_reg_bank
  import y86_pkg::*;
#(
  parameter int NSTAGES = 5,
  parameter int WIDTH   = 256,
  parameter int CNT_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NSTAGES-1:0]         stall,
  input  logic [NSTAGES-1:0]         bubble,
  input  logic [NSTAGES-1:0]         in_valid,
  input  logic [ICODE_W*NSTAGES-1:0] in_icode,
  input  logic [STAT_W*NSTAGES-1:0]  in_stat,
  input  logic [WIDTH*NSTAGES-1:0]   in_data,
  output logic [NSTAGES-1:0]         out_valid,
  output logic [ICODE_W*NSTAGES-1:0] out_icode,
  output logic [STAT_W*NSTAGES-1:0]  out_stat,
  output logic [WIDTH*NSTAGES-1:0]   out_data,
  output logic [NSTAGES-1:0]         exc_mask,
  output logic                       halted,
  output logic                       ctrl_err,
  output logic [CNT_W-1:0]           cycle_cnt,
  output logic [CNT_W-1:0]           retire_cnt
);

  localparam int LAST = NSTAGES - 1;

  logic retire_en;

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .freeze   (halted),
      .stall    (stall[k]),
      .bubble   (bubble[k]),
      .in_valid (in_valid[k]),
      .in_icode (in_icode[k*ICODE_W +: ICODE_W]),
      .in_stat  (in_stat[k*STAT_W +: STAT_W]),
      .in_data  (in_data[k*WIDTH +: WIDTH]),
      .out_valid(out_valid[k]),
      .out_icode(out_icode[k*ICODE_W +: ICODE_W]),
      .out_stat (out_stat[k*STAT_W +: STAT_W]),
      .out_data (out_data[k*WIDTH +: WIDTH])
    );
  end

  // Per-stage exceptional-status flags from registered state.
  always_comb begin
    exc_mask = '0;
    for (int k = 0; k < NSTAGES; k++) begin
      exc_mask[k] = out_valid[k]
                  & is_exc(out_stat[k*STAT_W +: STAT_W]);
    end
  end

  // Instruction leaving W this edge.
  always_comb begin
    retire_en = !halted
              && out_valid[LAST]
              && out_stat[LAST*STAT_W +: STAT_W] == STAT_AOK
              && !stall[LAST];
  end

  // Sticky freeze once an exception sits in the last stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted <= 1'b0;
    end else if (!halted && exc_mask[LAST]) begin
      halted <= 1'b1;
    end
  end

  // Sticky flag for conflicting stall+bubble requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_err <= 1'b0;
    end else if (|(stall & bubble)) begin
      ctrl_err <= 1'b1;
    end
  end

  // Saturating cycle counter, runs until halted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if (!halted && cycle_cnt != '1) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

  // Saturating retired-instruction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt <= '0;
    end else if (retire_en && retire_cnt != '1) begin
      retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_reg_bank.sv
// Self-checking bench for pipe_reg_bank: directed steps plus
// random traffic checked against a per-stage reference model.
module tb_pipe_reg_bank;

  localparam int NS = 5;
  localparam int W  = 32;
  localparam int CW = 32;
  localparam int L  = NS - 1;
  localparam int SW = 8;

  localparam logic [2:0] AOK = 3'd1;
  localparam logic [2:0] HLT = 3'd2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst_s = 1'b0;

  logic [NS-1:0]   stall, bubble, in_valid;
  logic [4*NS-1:0] in_icode;
  logic [3*NS-1:0] in_stat;
  logic [W*NS-1:0] in_data;

  logic [NS-1:0]   out_valid, exc_mask;
  logic [4*NS-1:0] out_icode;
  logic [3*NS-1:0] out_stat;
  logic [W*NS-1:0] out_data;
  logic            halted, ctrl_err;
  logic [CW-1:0]   cycle_cnt, retire_cnt;

  logic [NS-1:0]    z_ns;
  logic [4*NS-1:0]  z_ic;
  logic [3*NS-1:0]  z_st;
  logic [SW*NS-1:0] z_d;
  logic [NS-1:0]    s_valid, s_exc;
  logic [4*NS-1:0]  s_icode;
  logic [3*NS-1:0]  s_stat;
  logic [SW*NS-1:0] s_data;
  logic             s_halted, s_cerr;
  logic [3:0]       s_cyc, s_ret;

  int total = 0;
  int bad = 0;

  logic           m_valid[NS];
  logic [3:0]     m_icode[NS];
  logic [2:0]     m_stat[NS];
  logic [W-1:0]   m_data[NS];
  bit             m_halted, m_cerr;
  longint         m_cyc, m_ret;
  int             sat_n;
  longint         saved;

  string sched = "LLLSLBLBLLB";

  always #5 clk = ~clk;

  assign z_ns = '0;
  assign z_ic = '0;
  assign z_st = '0;
  assign z_d  = '0;

  pipe_reg_bank #(.NSTAGES(NS), .WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .stall(stall), .bubble(bubble),
    .in_valid(in_valid), .in_icode(in_icode),
    .in_stat(in_stat), .in_data(in_data),
    .out_valid(out_valid), .out_icode(out_icode),
    .out_stat(out_stat), .out_data(out_data),
    .exc_mask(exc_mask), .halted(halted),
    .ctrl_err(ctrl_err), .cycle_cnt(cycle_cnt),
    .retire_cnt(retire_cnt)
  );

  pipe_reg_bank #(.NSTAGES(NS), .WIDTH(SW), .CNT_W(4)) sat (
    .clk(clk), .rst(rst_s),
    .stall(z_ns), .bubble(z_ns),
    .in_valid(z_ns), .in_icode(z_ic),
    .in_stat(z_st), .in_data(z_d),
    .out_valid(s_valid), .out_icode(s_icode),
    .out_stat(s_stat), .out_data(s_data),
    .exc_mask(s_exc), .halted(s_halted),
    .ctrl_err(s_cerr), .cycle_cnt(s_cyc),
    .retire_cnt(s_ret)
  );

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NS; k++) begin
      m_valid[k] = 1'b0;
      m_icode[k] = 4'h1;
      m_stat[k]  = AOK;
      m_data[k]  = '0;
    end
    m_halted = 0;
    m_cerr   = 0;
    m_cyc    = 0;
    m_ret    = 0;
  endtask

  task automatic model_edge();
    bit nh;
    nh = m_halted || (m_valid[L] && m_stat[L] != AOK);
    if ((stall & bubble) != '0) m_cerr = 1;
    if (!m_halted) begin
      if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
      if (m_valid[L] && m_stat[L] == AOK && !stall[L]
          && m_ret < 64'hFFFF_FFFF) m_ret++;
      for (int k = 0; k < NS; k++) begin
        if (stall[k]) begin
        end else if (bubble[k]) begin
          m_valid[k] = 1'b0;
          m_icode[k] = 4'h1;
          m_stat[k]  = AOK;
          m_data[k]  = '0;
        end else begin
          m_valid[k] = in_valid[k];
          m_icode[k] = in_icode[k*4 +: 4];
          m_stat[k]  = in_stat[k*3 +: 3];
          m_data[k]  = in_data[k*W +: W];
        end
      end
    end
    m_halted = nh;
  endtask

  task automatic check_all(input string tag);
    logic [NS-1:0]   ev, ee;
    logic [4*NS-1:0] ei;
    logic [3*NS-1:0] es;
    logic [W*NS-1:0] ed;
    int sexp;
    for (int k = 0; k < NS; k++) begin
      ev[k]          = m_valid[k];
      ee[k]          = m_valid[k] && m_stat[k] != AOK;
      ei[k*4 +: 4]   = m_icode[k];
      es[k*3 +: 3]   = m_stat[k];
      ed[k*W +: W]   = m_data[k];
    end
    chk({tag, ".valid"}, out_valid, ev);
    chk({tag, ".icode"}, out_icode, ei);
    chk({tag, ".stat"},  out_stat, es);
    chk({tag, ".data"},  out_data, ed);
    chk({tag, ".exc"},   exc_mask, ee);
    chk({tag, ".halt"},  halted, m_halted);
    chk({tag, ".cerr"},  ctrl_err, m_cerr);
    chk({tag, ".cyc"},   cycle_cnt, m_cyc[CW-1:0]);
    chk({tag, ".ret"},   retire_cnt, m_ret[CW-1:0]);
    sexp = (sat_n > 15) ? 15 : sat_n;
    chk({tag, ".satcyc"}, s_cyc, sexp);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    sat_n++;
    #1;
    check_all(tag);
  endtask

  task automatic clear_in();
    stall    = '0;
    bubble   = '0;
    in_valid = '0;
    in_icode = {NS{4'h1}};
    in_stat  = {NS{AOK}};
    in_data  = '0;
  endtask

  task automatic set_stage(input int k, input logic v,
                           input logic [3:0] ic,
                           input logic [2:0] st,
                           input logic [W-1:0] d);
    in_valid[k]       = v;
    in_icode[k*4 +: 4] = ic;
    in_stat[k*3 +: 3]  = st;
    in_data[k*W +: W]  = d;
  endtask

  task automatic rand_in(input bit last_aok);
    for (int k = 0; k < NS; k++) begin
      stall[k]  = ($urandom_range(0, 3) == 0);
      bubble[k] = ($urandom_range(0, 3) == 0);
      set_stage(k, 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 11)),
                3'($urandom_range(1, 4)), $urandom);
    end
    if (last_aok) in_stat[L*3 +: 3] = AOK;
  endtask

  initial begin
    clear_in();
    #2;
    rst = 1'b1;
    rst_s = 1'b1;
    #1;
    model_reset();
    sat_n = 0;
    check_all("reset");
    #1;
    rst = 1'b0;
    rst_s = 1'b0;

    set_stage(2, 1'b1, 4'h6, AOK, 32'h1234);
    step("flow");
    chk("flow_data", out_data[2*W +: W], 32'h1234);
    chk("flow_icode", out_icode[2*4 +: 4], 4'h6);
    chk("flow_cyc", cycle_cnt, 1);

    clear_in();
    set_stage(1, 1'b1, 4'h3, AOK, 32'hAB);
    step("load1");
    stall[1] = 1'b1;
    set_stage(1, 1'b1, 4'h5, AOK, 32'hCD);
    step("stall1a");
    step("stall1b");
    chk("stall_hold", out_data[1*W +: W], 32'hAB);
    stall[1] = 1'b0;
    bubble[1] = 1'b1;
    step("bubble1");
    chk("bub_valid", out_valid[1], 1'b0);
    chk("bub_icode", out_icode[1*4 +: 4], 4'h1);
    chk("bub_data", out_data[1*W +: W], 0);

    clear_in();
    set_stage(3, 1'b1, 4'h2, AOK, 32'h77);
    step("load3");
    stall[3] = 1'b1;
    bubble[3] = 1'b1;
    set_stage(3, 1'b1, 4'h9, AOK, 32'h88);
    step("sb3");
    chk("sb_hold", out_data[3*W +: W], 32'h77);
    chk("sb_cerr", ctrl_err, 1'b1);

    for (int i = 0; i < 150; i++) begin
      rand_in(1'b1);
      step("rand");
    end

    #1;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("midrst");
    chk("midrst_cyc", cycle_cnt, 0);
    #1;
    rst = 1'b0;

    for (int i = 0; i < sched.len(); i++) begin
      clear_in();
      set_stage(L, 1'b1, 4'h6, AOK, $urandom);
      if (sched[i] == "S") stall[L] = 1'b1;
      if (sched[i] == "B") bubble[L] = 1'b1;
      step("retire");
    end
    chk("retire7", retire_cnt, 7);

    clear_in();
    set_stage(L, 1'b1, 4'h0, HLT, 32'h5);
    step("hlt_in");
    chk("hlt_exc", exc_mask[L], 1'b1);
    chk("hlt_pre", halted, 1'b0);
    rand_in(1'b0);
    step("hlt_edge");
    chk("hlt_set", halted, 1'b1);
    saved = m_cyc;
    for (int i = 0; i < 6; i++) begin
      rand_in(1'b0);
      if (i == 2) bubble[L] = 1'b1;
      step("frozen");
    end
    chk("hlt_cyc", cycle_cnt, saved[CW-1:0]);
    chk("sat_final", s_cyc, 4'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
